cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have parameter FETCH_TIMEOUT, default 8'd255, max wait cycles for mem_ready before fault.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port run  input  1  level; permits leaving IDLE and starting the next fetch.
REQ-006 SHALL have port mem_req  output  1  instruction fetch request.
REQ-007 SHALL have port mem_addr  output  16  fetch address; equals pc.
REQ-008 SHALL have port mem_ready  input  1  fetch data valid this cycle.
REQ-009 SHALL have port mem_rdata  input  16  fetched instruction word.
REQ-010 SHALL have port instr  output  16  instruction register driven to the decoder.
REQ-011 SHALL have port set_pc  input  1  jump taken, from the decoder.
REQ-012 SHALL have port jump_target  input  16  jump destination (A register value).
REQ-013 SHALL have port halt  input  1  stop after the current instruction commits.
REQ-014 SHALL have port exec_en  output  1  one-cycle commit strobe; gates A/D/M write enables.
REQ-015 SHALL have port pc  output  16  program counter.
REQ-016 SHALL have port retired  output  16  count of committed instructions.
REQ-017 SHALL have port fault  output  1  sticky fetch-timeout flag.
REQ-018 SHALL have port state  output  2  current state: IDLE=0, FETCH=1, EXEC=2, HALTED=3.

Function
REQ-019 SHALL be in IDLE with mem_req=0 and exec_en=0; go to FETCH on the first cycle run=1.
REQ-020 SHALL assert mem_req and hold mem_addr=pc in FETCH until mem_ready=1 (req may not drop early).
REQ-021 SHALL, on mem_ready=1 in FETCH, latch mem_rdata into instr and go to EXEC next cycle; zero-wait memory therefore gives 2 cycles per instruction.
REQ-022 SHALL hold instr stable except on the mem_ready capture edge.
REQ-023 SHALL assert exec_en for exactly the one EXEC cycle; exec_en=0 in every other state.
REQ-024 SHALL, at the end of EXEC, update pc to jump_target if set_pc=1, else pc+1 modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-025 SHALL increment retired by 1 modulo 2^16 at the end of each EXEC.
REQ-026 SHALL choose the state after EXEC by priority: HALTED if halt=1; else FETCH if run=1; else IDLE.
REQ-027 SHALL sample halt only in EXEC; halt in IDLE or FETCH has no effect until the next EXEC.
REQ-028 SHALL remain in HALTED, with pc, instr and retired frozen, until rst.
REQ-029 SHALL count FETCH wait cycles; when the count reaches FETCH_TIMEOUT without mem_ready, set fault=1, drop mem_req and go to HALTED.
REQ-030 SHALL give mem_ready priority over the timeout when both occur in the same cycle (instruction captured, no fault).
REQ-031 SHALL ignore mem_ready outside FETCH.

Reset
REQ-032 SHALL, on rst assertion at any time including mid-fetch, immediately force: state=IDLE, pc=RESET_PC, instr=16'h0000, retired=0, fault=0, mem_req=0, exec_en=0, timeout counter=0.
REQ-033 SHALL begin the first fetch no earlier than the first rising clk edge after rst deasserts with run=1.

Structure
REQ-034 SHALL take the state encodings and the default RESET_PC from the shared CPU package, which the decoder and bench also use.
REQ-035 SHALL be a single module with no sub-modules; next-state logic and registers are in the same file.

Verification
REQ-036 Bench SHALL cover: rst, run=1, mem_ready tied 1, set_pc=0 -> mem_addr 0,0,1,1,2,2 across alternate cycles; exec_en pulses every 2nd cycle; retired=3 after 6 cycles.
REQ-037 Bench SHALL cover: mem_ready delayed 3 cycles -> mem_req held 4 cycles at a constant address; instr updates once; a single exec_en pulse.
REQ-038 Bench SHALL cover: set_pc=1 with jump_target=16'h1234 during EXEC -> next mem_addr=16'h1234; pc=16'hFFFF with no jump -> next pc=16'h0000.
REQ-039 Bench SHALL cover: halt=1 in EXEC -> that instruction commits (retired+1), state=3 and mem_req=0 held for 20 cycles.
REQ-040 Bench SHALL cover: FETCH_TIMEOUT=4 with mem_ready=0 -> fault=1 and state=3 after 4 wait cycles; mem_ready coinciding with the 4th cycle -> fault=0.
REQ-041 Bench SHALL cover: rst asserted mid-FETCH between clock edges -> mem_req=0 and pc=RESET_PC before the next edge.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - shared CPU state encodings, reset defaults and pc helper
package cpu_sequencer_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam logic [15:0] DEFAULT_RESET_PC      = 16'h0000;
    localparam logic [7:0]  DEFAULT_FETCH_TIMEOUT = 8'd255;

    // Sequential pc wraps naturally at 16 bits.
    function automatic logic [15:0] next_pc(input logic [15:0] cur_pc,
                                            input logic        take_jump,
                                            input logic [15:0] target);
        return take_jump ? target : cur_pc + 16'd1;
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/execute sequencer with fetch timeout and halt
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC      = DEFAULT_RESET_PC,
    parameter logic [7:0]  FETCH_TIMEOUT = DEFAULT_FETCH_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    input  logic        set_pc,
    input  logic [15:0] jump_target,
    input  logic        halt,
    output logic        exec_en,
    output logic [15:0] pc,
    output logic [15:0] retired,
    output logic        fault,
    output logic [1:0]  state
);

    logic [1:0]  state_q;
    logic [15:0] pc_q;
    logic [15:0] instr_q;
    logic [15:0] retired_q;
    logic        fault_q;
    logic [7:0]  wait_cnt;
    logic        timeout_hit;

    // The current cycle is the last allowed wait when it brings the count up to the limit.
    assign timeout_hit = ({1'b0, wait_cnt} + 9'd1) >= {1'b0, FETCH_TIMEOUT};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 16'h0000;
            retired_q <= 16'h0000;
            fault_q   <= 1'b0;
            wait_cnt  <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        instr_q  <= mem_rdata;
                        state_q  <= ST_EXEC;
                        wait_cnt <= 8'd0;
                    end else if (timeout_hit) begin
                        fault_q  <= 1'b1;
                        state_q  <= ST_HALTED;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_EXEC: begin
                    pc_q      <= next_pc(pc_q, set_pc, jump_target);
                    retired_q <= retired_q + 16'd1;
                    if (halt) begin
                        state_q <= ST_HALTED;
                    end else if (run) begin
                        state_q <= ST_FETCH;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_HALTED;
                end
            endcase
        end
    end

    // Strobes decode straight from state so reset clears them without waiting for a clock.
    assign mem_req  = (state_q == ST_FETCH);
    assign exec_en  = (state_q == ST_EXEC);
    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign instr    = instr_q;
    assign retired  = retired_q;
    assign fault    = fault_q;
    assign state    = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic        set_pc;
    logic [15:0] jump_target;
    logic        halt;
    logic        exec_en;
    logic [15:0] pc;
    logic [15:0] retired;
    logic        fault;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    logic [15:0] mpc;
    logic [15:0] mret;
    logic [15:0] minstr;
    logic        mfault;

    int          r;
    logic        hlt;
    logic        rn;

    cpu_sequencer #(
        .RESET_PC      (DEFAULT_RESET_PC),
        .FETCH_TIMEOUT (8'd4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .set_pc      (set_pc),
        .jump_target (jump_target),
        .halt        (halt),
        .exec_en     (exec_en),
        .pc          (pc),
        .retired     (retired),
        .fault       (fault),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_state",   16'(state),   16'd0);
        check("rst_req",     16'(mem_req), 16'd0);
        check("rst_exec",    16'(exec_en), 16'd0);
        check("rst_pc",      pc,           DEFAULT_RESET_PC);
        check("rst_addr",    mem_addr,     DEFAULT_RESET_PC);
        check("rst_instr",   instr,        16'h0000);
        check("rst_retired", retired,      16'h0000);
        check("rst_fault",   16'(fault),   16'd0);
        mpc    = DEFAULT_RESET_PC;
        mret   = 16'h0000;
        minstr = 16'h0000;
        mfault = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Spend idle_n cycles with run low, then raise run so the next cycle fetches.
    task automatic enter_fetch(input int idle_n);
        for (int i = 0; i <= idle_n; i++) begin
            run       = (i == idle_n);
            mem_ready = 1'($urandom);
            halt      = 1'($urandom);
            set_pc    = 1'($urandom);
            @(negedge clk);
            check("idle_state",   16'(state),   16'd0);
            check("idle_req",     16'(mem_req), 16'd0);
            check("idle_exec",    16'(exec_en), 16'd0);
            check("idle_pc",      pc,           mpc);
            check("idle_retired", retired,      mret);
            step();
        end
    endtask

    // One instruction: w wait cycles, then capture, then the commit cycle.
    task automatic txn(input int w, input logic [15:0] rdata, input logic sp,
                       input logic [15:0] tgt, input logic h, input logic rnext);
        for (int i = 0; i <= w; i++) begin
            mem_ready   = (i == w);
            mem_rdata   = (i == w) ? rdata : 16'($urandom);
            set_pc      = 1'($urandom);
            jump_target = 16'($urandom);
            halt        = 1'($urandom);
            run         = 1'($urandom);
            @(negedge clk);
            check("fetch_state",   16'(state),   16'd1);
            check("fetch_req",     16'(mem_req), 16'd1);
            check("fetch_exec",    16'(exec_en), 16'd0);
            check("fetch_addr",    mem_addr,     mpc);
            check("fetch_instr",   instr,        minstr);
            check("fetch_retired", retired,      mret);
            check("fetch_fault",   16'(fault),   16'(mfault));
            step();
        end
        mem_ready   = 1'($urandom);
        mem_rdata   = 16'($urandom);
        set_pc      = sp;
        jump_target = tgt;
        halt        = h;
        run         = rnext;
        @(negedge clk);
        check("exec_state", 16'(state),   16'd2);
        check("exec_en",    16'(exec_en), 16'd1);
        check("exec_req",   16'(mem_req), 16'd0);
        check("exec_addr",  mem_addr,     mpc);
        check("exec_instr", instr,        rdata);
        step();
        minstr = rdata;
        mpc    = sp ? tgt : mpc + 16'd1;
        mret   = mret + 16'd1;
    endtask

    task automatic halted_hold(input int n);
        for (int i = 0; i < n; i++) begin
            run       = 1'($urandom);
            mem_ready = 1'($urandom);
            mem_rdata = 16'($urandom);
            set_pc    = 1'($urandom);
            halt      = 1'($urandom);
            @(negedge clk);
            check("halt_state",   16'(state),   16'd3);
            check("halt_req",     16'(mem_req), 16'd0);
            check("halt_exec",    16'(exec_en), 16'd0);
            check("halt_pc",      pc,           mpc);
            check("halt_instr",   instr,        minstr);
            check("halt_retired", retired,      mret);
            check("halt_fault",   16'(fault),   16'(mfault));
            step();
        end
    endtask

    // Four fetch cycles with no data exhaust a timeout of 4.
    task automatic timeout_txn();
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b0;
            run       = 1'($urandom);
            @(negedge clk);
            check("to_state", 16'(state),   16'd1);
            check("to_req",   16'(mem_req), 16'd1);
            check("to_addr",  mem_addr,     mpc);
            check("to_fault", 16'(fault),   16'd0);
            step();
        end
        mfault = 1'b1;
        halted_hold(5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0000;
        set_pc = 1'b0; jump_target = 16'h0000; halt = 1'b0;
        mpc = DEFAULT_RESET_PC; mret = 16'h0000; minstr = 16'h0000; mfault = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Zero-wait memory: two cycles per instruction.
        enter_fetch(0);
        txn(0, 16'hA001, 1'b0, 16'h0000, 1'b0, 1'b1);
        txn(0, 16'hA002, 1'b0, 16'h0000, 1'b0, 1'b1);
        txn(0, 16'hA003, 1'b0, 16'h0000, 1'b0, 1'b1);
        check("retired_after_6", retired, 16'd3);

        txn(3, 16'hB00B, 1'b0, 16'h0000, 1'b0, 1'b1);

        txn(0, 16'hC001, 1'b1, 16'h1234, 1'b0, 1'b1);
        check("jump_addr", mem_addr, 16'h1234);
        txn(1, 16'hC002, 1'b1, 16'hFFFF, 1'b0, 1'b1);
        txn(0, 16'hC003, 1'b0, 16'h0000, 1'b0, 1'b1);
        check("pc_wrap", pc, 16'h0000);

        // Data arriving on the final allowed wait cycle wins over the timeout.
        txn(3, 16'hD004, 1'b0, 16'h0000, 1'b0, 1'b1);

        txn(2, 16'hE005, 1'b0, 16'h0000, 1'b1, 1'b1);
        halted_hold(20);

        do_reset();
        enter_fetch(1);
        #1;
        check("mid_fetch_req", 16'(mem_req), 16'd1);
        do_reset();

        enter_fetch(0);
        timeout_txn();
        do_reset();
        enter_fetch(0);

        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                timeout_txn();
                do_reset();
                enter_fetch(int'($urandom_range(0, 2)));
            end else begin
                hlt = (r == 1);
                rn  = ($urandom_range(0, 3) != 0);
                txn(int'($urandom_range(0, 3)), 16'($urandom), ($urandom_range(0, 3) == 0),
                    16'($urandom), hlt, rn);
                if (hlt) begin
                    halted_hold(4);
                    do_reset();
                    enter_fetch(0);
                end else if (!rn) begin
                    enter_fetch(int'($urandom_range(0, 2)));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
